// File: rtl/tc_store_buffer.sv
// Store buffer: circular FIFO of pending RAM stores with load forwarding.
// Optional store coalescing into the youngest entry: STORE_BUFFER_COALESCE_EN.
module tc_store_buffer #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int BIT_WIDTH = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_valid,
    input  logic [15:0]          wr_addr,
    input  logic [BIT_WIDTH-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 port0_busy,
    output logic                 ram_save,
    output logic [15:0]          ram_address0,
    output logic [BIT_WIDTH-1:0] ram_in,
    input  logic [15:0]          rd_addr,
    output logic                 fwd_hit,
    output logic [BIT_WIDTH-1:0] fwd_data,
    output logic                 empty,
    output logic                 overflow
);

    localparam int          PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int          CW = $clog2(DEPTH + 1);
    localparam int unsigned DU = DEPTH;

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("tc_store_buffer %s (%0d): DEPTH must be 2..16", NAME, UUID);
    end

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p,
                                               input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= DU) s = s - DU;
        return s[PW-1:0];
    endfunction

    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          addr_q [DEPTH];
    logic [BIT_WIDTH-1:0] data_q [DEPTH];

    logic full, is_empty, push, pop, coal;
    logic                 hit;
    logic [BIT_WIDTH-1:0] hit_data;

    assign full     = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);

    assign empty    = !rst || is_empty;
    assign wr_ready = rst && !full;
    assign ram_save = rst && !is_empty && !port0_busy;
    assign pop      = ram_save;
    assign overflow = overflow_q;

    assign ram_address0 = (rst && !is_empty) ? addr_q[head_q] : '0;
    assign ram_in       = (rst && !is_empty) ? data_q[head_q] : '0;

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PW-1:0] young;
    assign young = wrap_add(tail_q, DU - 1);
    // The head cannot absorb new data once the RAM is taking it this cycle.
    assign coal  = wr_valid && valid_q[young]
                && (addr_q[young] == wr_addr)
                && !((young == head_q) && ram_save);
`else
    assign coal  = 1'b0;
`endif

    assign push = wr_valid && wr_ready && !coal;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = wrap_add(head_q, 1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = wrap_add(tail_q, 1);
        end
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (wr_valid && full && !coal) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload needs no reset: valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= wr_addr;
            data_q[tail_q] <= wr_data;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        if (coal) data_q[young] <= wr_data;
`endif
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin : fwd_search
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = wrap_add(head_q, i);
            if (valid_q[idx] && (addr_q[idx] == rd_addr)) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign fwd_hit  = rst && hit;
    assign fwd_data = (rst && hit) ? hit_data : '0;

endmodule

// File: tb/tb_tc_store_buffer.sv
// Bench for tc_store_buffer: vector table plus hand sequences, with a
// scoreboard of expected RAM writes checked as the RAM captures them.
module tb_tc_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        port0_busy = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        wr_ready, ram_save, fwd_hit, empty, overflow;
    logic [15:0] ram_address0, ram_in, fwd_data;

    always #5 clk = ~clk;

    tc_store_buffer #(
        .UUID(0), .NAME("sb0"), .BIT_WIDTH(16), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .port0_busy(port0_busy),
        .ram_save(ram_save), .ram_address0(ram_address0), .ram_in(ram_in),
        .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .empty(empty), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] d;
        logic        b;
        logic [15:0] r;
        logic        e_rdy;
        logic        e_hit;
        logic [15:0] e_fwd;
        logic        e_empty;
        logic        e_save;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    st_t         sbq[$];
    int          cnt_m = 0;
    logic [15:0] last_a = '0;
    logic [15:0] mem [256];
    vec_t        tbl [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // RAM model and scoreboard: the RAM captures on the falling edge.
    always @(negedge clk) begin
        if (ram_save) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr got %h want none", ram_address0);
            end else begin
                st_t e;
                e = sbq.pop_front();
                chk("sb_addr", 32'(ram_address0), 32'(e.a));
                chk("sb_data", 32'(ram_in), 32'(e.d));
            end
            mem[ram_address0[7:0]] = ram_in;
        end
    end

    task automatic drv(input logic v, input logic [15:0] a,
                       input logic [15:0] d, input logic b,
                       input logic [15:0] r);
        wr_valid   = v;
        wr_addr    = a;
        wr_data    = d;
        port0_busy = b;
        rd_addr    = r;
        #1;
    endtask

    // Update the reference model for this cycle, then take the edge.
    task automatic tick();
        logic sv;
        logic coal;
        st_t  e;
        sv   = (cnt_m > 0) && !port0_busy;
        coal = 1'b0;
`ifdef STORE_BUFFER_COALESCE_EN
        if (wr_valid && cnt_m > 0 && last_a == wr_addr && !(cnt_m == 1 && sv)) begin
            coal = 1'b1;
            sbq[sbq.size()-1].d = wr_data;
        end
`endif
        if (!coal && wr_valid && cnt_m < DEPTH) begin
            e.a = wr_addr;
            e.d = wr_data;
            sbq.push_back(e);
            cnt_m++;
            last_a = wr_addr;
        end
        if (sv) cnt_m--;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int exp_n);
        int n;
        n = 0;
        for (int k = 0; k < 2 * DEPTH; k++) begin
            drv(1'b0, '0, '0, 1'b0, '0);
            if (ram_save) n++;
            tick();
        end
        chk(nm, 32'(n), 32'(exp_n));
    endtask

    initial begin
        int exp_n;
        for (int i = 0; i < 256; i++) mem[i] = '0;

        tbl[0]  = '{1'b1, 16'h10, 16'hAAAA, 1'b1, 16'h10, 1'b1, 1'b0, 16'h0,    1'b1, 1'b0};
        tbl[1]  = '{1'b1, 16'h11, 16'hBBBB, 1'b1, 16'h10, 1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 16'h10, 16'hCCCC, 1'b1, 16'h11, 1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 16'h0,  16'h0,    1'b1, 16'h10, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 16'h12, 16'hDDDD, 1'b1, 16'h13, 1'b1, 1'b0, 16'h0,    1'b0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0,  16'h0,    1'b1, 16'h12, 1'b0, 1'b1, 16'hDDDD, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0,  16'h0,    1'b0, 16'h10, 1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 16'h0,  16'h0,    1'b0, 16'h10, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 16'h14, 16'hEEEE, 1'b0, 16'h10, 1'b1, 1'b1, 16'hCCCC, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 16'h0,  16'h0,    1'b0, 16'h10, 1'b1, 1'b0, 16'h0,    1'b0, 1'b1};
        tbl[10] = '{1'b0, 16'h0,  16'h0,    1'b0, 16'h14, 1'b1, 1'b1, 16'hEEEE, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 16'h0,  16'h0,    1'b0, 16'h14, 1'b1, 1'b0, 16'h0,    1'b1, 1'b0};

        // Outputs while held in reset, with live-looking inputs.
        drv(1'b1, 16'h10, 16'h1, 1'b0, 16'h10);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_save", 32'(ram_save), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_hit", 32'(fwd_hit), 32'd0);
        chk("rst_fwd", 32'(fwd_data), 32'd0);
        chk("rst_addr", 32'(ram_address0), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_empty_edge", 32'(empty), 32'd1);

        // Release reset; the first row pushes on the very next edge.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drv(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].r);
            chk($sformatf("t%0d_rdy", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("t%0d_hit", i), 32'(fwd_hit), 32'(tbl[i].e_hit));
            chk($sformatf("t%0d_fwd", i), 32'(fwd_data), 32'(tbl[i].e_fwd));
            chk($sformatf("t%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
            chk($sformatf("t%0d_save", i), 32'(ram_save), 32'(tbl[i].e_save));
            tick();
        end
        chk("t_mem10", 32'(mem[8'h10]), 32'hCCCC);
        chk("t_mem11", 32'(mem[8'h11]), 32'hBBBB);
        chk("t_mem12", 32'(mem[8'h12]), 32'hDDDD);
        chk("t_mem14", 32'(mem[8'h14]), 32'hEEEE);
        chk("t_sb_left", 32'(sbq.size()), 32'd0);
        chk("t_idle_addr", 32'(ram_address0), 32'd0);
        chk("t_idle_in", 32'(ram_in), 32'd0);

        // Fill past full while the port is busy.
        for (int k = 0; k < 5; k++) begin
            drv(1'b1, 16'h30 + 16'(k), 16'h3000 + 16'(k), 1'b1, '0);
            chk($sformatf("of%0d_rdy", k), 32'(wr_ready), (k < 4) ? 32'd1 : 32'd0);
            tick();
        end
        chk("of_flag", 32'(overflow), 32'd1);
        drv(1'b0, '0, '0, 1'b1, '0);
        tick();
        tick();
        chk("of_sticky", 32'(overflow), 32'd1);
        drain("of_drain_n", 4);
        chk("of_sticky_drained", 32'(overflow), 32'd1);
        chk("of_mem33", 32'(mem[8'h33]), 32'h3003);
        chk("of_mem34", 32'(mem[8'h34]), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cnt_m = 0;
        sbq.delete();
        #1;
        chk("of_clr", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Same-address stores: youngest data forwards.
        drv(1'b1, 16'h20, 16'h1, 1'b1, 16'h20);
        tick();
        drv(1'b1, 16'h20, 16'h2, 1'b1, 16'h20);
        chk("fw_hit_old", 32'(fwd_hit), 32'd1);
        chk("fw_data_old", 32'(fwd_data), 32'd1);
        tick();
        drv(1'b0, '0, '0, 1'b1, 16'h20);
        chk("fw_hit", 32'(fwd_hit), 32'd1);
        chk("fw_data", 32'(fwd_data), 32'd2);
`ifdef STORE_BUFFER_COALESCE_EN
        exp_n = 1;
`else
        exp_n = 2;
`endif
        drain("fw_drain_n", exp_n);
        chk("fw_mem20", 32'(mem[8'h20]), 32'd2);

        // Steady push/pop at count 1; pointers wrap several times.
        drv(1'b1, 16'h50, 16'h1000, 1'b0, '0);
        chk("pp_save0", 32'(ram_save), 32'd0);
        tick();
        for (int k = 1; k <= 10; k++) begin
            drv(1'b1, 16'h50 + 16'(k), 16'h1000 + 16'(k), 1'b0, '0);
            chk($sformatf("pp%0d_save", k), 32'(ram_save), 32'd1);
            chk($sformatf("pp%0d_rdy", k), 32'(wr_ready), 32'd1);
            chk($sformatf("pp%0d_empty", k), 32'(empty), 32'd0);
            tick();
        end
        drv(1'b0, '0, '0, 1'b0, '0);
        chk("pp_last_save", 32'(ram_save), 32'd1);
        tick();
        chk("pp_empty", 32'(empty), 32'd1);
        for (int k = 0; k <= 10; k++)
            chk($sformatf("pp_mem%0d", k), 32'(mem[8'h50 + 8'(k)]), 32'h1000 + 32'(k));

        // Reset mid-drain with three stores pending.
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 16'h40 + 16'(k), 16'h4000 + 16'(k), 1'b1, '0);
            tick();
        end
        drv(1'b0, '0, '0, 1'b0, 16'h41);
        chk("mr_save_pre", 32'(ram_save), 32'd1);
        chk("mr_hit_pre", 32'(fwd_hit), 32'd1);
        #1;
        rst = 1'b0;
        sbq.delete();
        cnt_m = 0;
        #1;
        chk("mr_save", 32'(ram_save), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_rdy", 32'(wr_ready), 32'd0);
        chk("mr_hit", 32'(fwd_hit), 32'd0);
        chk("mr_addr", 32'(ram_address0), 32'd0);
        chk("mr_in", 32'(ram_in), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_empty_after", 32'(empty), 32'd1);
        chk("mr_save_after", 32'(ram_save), 32'd0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("mr_mem%0d", k), 32'(mem[8'h40 + 8'(k)]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_store_buffer.md
TC_STORE_BUFFER -- requirements
Module: tc_store_buffer

Interface
REQ-001 The block SHALL have parameter UUID, default 0, meaning the instance identifier; it is passed through and unused in logic.
REQ-002 The block SHALL have parameter NAME, default "", meaning the instance label; it is passed through and unused in logic.
REQ-003 The block SHALL have parameter BIT_WIDTH, default 16, meaning the data width in bits.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning the number of buffer entries; the legal range is 2..16.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port wr_valid, input, 1 bit: the upstream store request.
REQ-008 The block SHALL have port wr_addr, input, 16 bits: the store address.
REQ-009 The block SHALL have port wr_data, input, BIT_WIDTH bits: the store data.
REQ-010 The block SHALL have port wr_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-011 The block SHALL have port port0_busy, input, 1 bit: the downstream RAM port 0 is being used for a load this cycle.
REQ-012 The block SHALL have port ram_save, output, 1 bit, which drives the RAM save input.
REQ-013 The block SHALL have port ram_address0, output, 16 bits, which drives the RAM address0 input.
REQ-014 The block SHALL have port ram_in, output, BIT_WIDTH bits, which drives the RAM data input.
REQ-015 The block SHALL have port rd_addr, input, 16 bits: the load address to snoop for forwarding.
REQ-016 The block SHALL have port fwd_hit, output, 1 bit: a buffered store matches rd_addr.
REQ-017 The block SHALL have port fwd_data, output, BIT_WIDTH bits: the data of the youngest matching store.
REQ-018 The block SHALL have port empty, output, 1 bit: no entries are held.
REQ-019 The block SHALL have port overflow, output, 1 bit: a sticky error flag for a push attempted while full.

Function
REQ-020 The block SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, and a count in the range 0..DEPTH.
REQ-021 The block SHALL drive wr_ready = rst && (count < DEPTH), combinationally, with no dependence on wr_valid.
REQ-022 A push SHALL occur on the rising edge where wr_valid && wr_ready; the store is written at the tail and the tail advances.
REQ-023 The block SHALL drive ram_save = !empty && !port0_busy && rst, combinationally.
REQ-024 ram_address0 and ram_in SHALL equal the head entry; they are zero when empty.
REQ-025 The RAM captures the store on the falling edge within the same cycle; a pop SHALL occur on the next rising edge whenever ram_save = 1, giving a drain latency of 1 cycle per entry.
REQ-026 When port0_busy = 1, the block SHALL NOT pop; the head is held and ram_save = 0.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; this is legal at any count below DEPTH.
REQ-028 When full (count = DEPTH), a push SHALL NOT occur even if a pop happens in the same cycle.
REQ-029 wr_valid asserted while full SHALL set overflow to 1 on that rising edge; the flag is cleared only by reset, and the data is dropped.
REQ-030 fwd_hit SHALL be combinational: the OR over valid entries of (entry address == rd_addr).
REQ-031 fwd_data SHALL be the youngest matching entry's data, or zero when there is no hit.
REQ-032 A store being pushed in the same cycle SHALL NOT be forwarded.
REQ-033 An entry SHALL remain forwardable through the cycle in which it drains.
REQ-034 The block SHALL drive empty = (count == 0).

Reset
REQ-035 When rst = 0, the block SHALL immediately and asynchronously clear head, tail, count, all entry valid bits and overflow.
REQ-036 While rst = 0, the block SHALL drive ram_save = 0, wr_ready = 0, fwd_hit = 0, empty = 1, and ram_address0, ram_in and fwd_data to zero.
REQ-037 Reset asserted mid-drain SHALL discard all pending stores; no RAM write occurs while rst = 0.
REQ-038 After rst rises, the block SHALL accept a push on the first rising edge.

Configuration
REQ-039 With STORE_BUFFER_COALESCE_EN defined, a push whose wr_addr equals the youngest valid entry's address SHALL overwrite that entry's data without allocating a new entry or changing count.
REQ-040 With STORE_BUFFER_COALESCE_EN defined, coalescing SHALL NOT apply when that entry is the head and ram_save = 1 in that cycle; a normal push occurs instead.
REQ-041 With STORE_BUFFER_COALESCE_EN defined, a coalescing push SHALL be accepted even when full.
REQ-042 Without STORE_BUFFER_COALESCE_EN, every accepted push SHALL allocate a new entry.

Verification
REQ-043 Scenario: with port0_busy = 1, push (0x10, 0xAAAA), (0x11, 0xBBBB), then release -> ram_save pulses 2 cycles, RAM[0x10] = 0xAAAA, RAM[0x11] = 0xBBBB, empty = 1.
REQ-044 Scenario: DEPTH = 4, port0_busy = 1, push 5 stores -> wr_ready = 0 after the 4th, the 5th is dropped, overflow = 1 and stays 1 until rst = 0.
REQ-045 Scenario: push (0x20, 1) then (0x20, 2), rd_addr = 0x20 -> fwd_hit = 1, fwd_data = 2; without the macro count = 2, with the macro count = 1.
REQ-046 Scenario: run 10 push/pop pairs at count = 1 -> pointers wrap, count stays 1, and RAM contents equal the stores in order.
REQ-047 Scenario: 3 entries pending, rst = 0 mid-cycle -> ram_save falls immediately, empty = 1, the RAM is unchanged afterwards.
